// File: rtl/aes_decryption.sv
// aes_decryption: byte-serial AES-128 decryption core that runs one round per clock with an on-the-fly inverse key schedule
// Ports: clk, rst (async, active high); in_valid/key_byte/cipher_byte/in_ready load one key and ciphertext byte pair per accept;
// busy is high from the first accepted byte until the last output byte; out_valid/plain_byte stream 16 plaintext bytes.
module aes_decryption #(
  parameter logic IN_LSB_FIRST = 1'b0,
  parameter logic OUT_LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] key_byte,
  input  logic [7:0] cipher_byte,
  output logic       in_ready,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] plain_byte
);
  typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, INIT, ROUND, FINAL, OUTPUT} stateT;
  localparam logic [127:0] RCON = {80'h01020408102040801b36, 48'h0};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, q;
    r = 8'h01;
    q = a;
    for (int i = 1; i < 8; i++) begin
      q = gmul(q, q);
      r = gmul(r, q);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // byte 4c+r of the block is row r of column c, byte 0 at [127:120]
  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = invSbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  stateT st, nxt;
  logic [127:0] key, s, keyNext, shifted, roundOut;
  logic [31:0] w0, w1, w2, w3, rotIn, sw, f0, f1, f2, f3;
  logic [7:0] rc, outByte, last;
  logic [3:0] idx, rnd, wIdx, pos, oPos;
  logic acc;

  assign in_ready = st == IDLE || st == LOAD;
  assign busy = st != IDLE;
  assign out_valid = st == OUTPUT;
  assign acc = in_valid && in_ready;
  assign plain_byte = out_valid ? outByte : last;

  // forward and inverse key steps share one SubWord; only its input word differs
  always_comb begin
    {w0, w1, w2, w3} = key;
    rc = RCON[{~rnd, 3'b0} +: 8];
    rotIn = st == KEYEXP ? w3 : w3 ^ w2;
    sw = subWord({rotIn[23:0], rotIn[31:24]}) ^ {rc, 24'h0};
    f0 = w0 ^ sw;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    keyNext = st == KEYEXP ? {f0, f1, f2, f3} : {w0 ^ sw, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    shifted = invShiftSub(s) ^ key;
    roundOut = invMix(shifted);
    wIdx = st == IDLE ? 4'd0 : idx;
    pos = IN_LSB_FIRST ? wIdx : ~wIdx;
    oPos = OUT_LSB_FIRST ? idx : ~idx;
    outByte = s[{oPos, 3'b0} +: 8];
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = acc ? LOAD : IDLE;
      LOAD:    nxt = acc && idx == 4'd15 ? KEYEXP : LOAD;
      KEYEXP:  nxt = rnd == 4'd9 ? INIT : KEYEXP;
      INIT:    nxt = ROUND;
      ROUND:   nxt = rnd == 4'd0 ? FINAL : ROUND;
      FINAL:   nxt = OUTPUT;
      OUTPUT:  nxt = idx == 4'd15 ? IDLE : OUTPUT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      idx <= 4'd0;
      rnd <= 4'd0;
      key <= '0;
      s <= '0;
      last <= 8'h00;
    end else begin
      st <= nxt;
      case (st)
        IDLE, LOAD: if (acc) begin
          key[{pos, 3'b0} +: 8] <= key_byte;
          s[{pos, 3'b0} +: 8] <= cipher_byte;
          idx <= st == IDLE ? 4'd1 : idx + {3'b0, idx != 4'd15};
          rnd <= 4'd0;
        end
        KEYEXP: begin
          key <= keyNext;
          rnd <= rnd + {3'b0, rnd != 4'd9};
        end
        INIT: begin
          s <= s ^ key;
          key <= keyNext;
          rnd <= rnd - 4'd1;
        end
        ROUND: begin
          s <= roundOut;
          key <= keyNext;
          rnd <= rnd - {3'b0, rnd != 4'd0};
        end
        FINAL: begin
          s <= shifted;
          idx <= 4'd0;
        end
        OUTPUT: begin
          last <= outByte;
          idx <= idx + {3'b0, idx != 4'd15};
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aes_decryption.sv
// tb_aes_decryption: directed FIPS-197 vectors against the byte-serial AES-128 decryption core
module tb_aes_decryption;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_valid1 = 1'b0;
  logic [7:0] key_byte = 8'h00, cipher_byte = 8'h00, key_byte1 = 8'h00, cipher_byte1 = 8'h00;
  logic in_ready, busy, out_valid, in_ready1, busy1, out_valid1;
  logic [7:0] plain_byte, plain_byte1;
  int cyc = 0;
  int checks = 0, errors = 0;

  aes_decryption u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .key_byte(key_byte), .cipher_byte(cipher_byte),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .plain_byte(plain_byte));

  aes_decryption #(.IN_LSB_FIRST(1'b1), .OUT_LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .key_byte(key_byte1), .cipher_byte(cipher_byte1),
    .in_ready(in_ready1), .busy(busy1), .out_valid(out_valid1), .plain_byte(plain_byte1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // u selects the LSB-first instance, which receives bytes low end first like the encryption top emits them
  task automatic feed(input bit u, input logic [127:0] k, input logic [127:0] c, input bit gap, output int t);
    t = 0;
    for (int i = 0; i < 16; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (u) begin
        in_valid1 = 1'b1;
        key_byte1 = k[8*i +: 8];
        cipher_byte1 = c[8*i +: 8];
      end else begin
        in_valid = 1'b1;
        key_byte = k[127-8*i -: 8];
        cipher_byte = c[127-8*i -: 8];
      end
      t = cyc;
    end
  endtask

  task automatic collect(input bit u, input int t, input bit junk, output logic [127:0] pt, output int lat, output int n);
    n = 0;
    lat = -1;
    pt = '0;
    for (int c = 0; c < 60 && n < 16; c++) begin
      @(negedge clk);
      if (u ? out_valid1 : out_valid) begin
        if (n == 0) lat = cyc - t;
        pt = u ? {plain_byte1, pt[127:8]} : {pt[119:0], plain_byte};
        n++;
      end else if (n > 0) break;
      in_valid = junk && n < 16 && (c % 2 == 1);
      key_byte = 8'($urandom);
      cipher_byte = 8'($urandom);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    int t, lat, n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_plain_byte", plain_byte, 8'h00);
    rst = 1'b0;

    feed(0, K1, C1, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    chk("c1_in_ready_low", in_ready, 1'b0);
    chk("c1_busy", busy, 1'b1);
    collect(0, t, 0, pt, lat, n);
    chk("c1_plain", pt, P1);
    chk("c1_latency", lat, 22);
    chk("c1_count", n, 16);
    @(negedge clk);
    chk("c1_done_out_valid", out_valid, 1'b0);
    chk("c1_done_busy", busy, 1'b0);
    chk("c1_done_in_ready", in_ready, 1'b1);
    chk("c1_hold_byte", plain_byte, 8'hff);

    feed(0, K2, C2, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    chk("b_rk10_next", u0.keyNext, RK10);
    @(negedge clk);
    chk("b_rk10_reg", u0.key, RK10);
    collect(0, t, 0, pt, lat, n);
    chk("b_plain", pt, P2);
    chk("b_latency", lat, 22);

    feed(0, K1, C1, 1, t);
    @(negedge clk);
    in_valid = 1'b0;
    collect(0, t, 0, pt, lat, n);
    chk("gap_plain", pt, P1);
    chk("gap_latency", lat, 22);

    feed(0, K1, C1, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    collect(0, t, 1, pt, lat, n);
    chk("junk_plain", pt, P1);
    chk("junk_latency", lat, 22);
    @(negedge clk);
    chk("junk_in_ready", in_ready, 1'b1);
    feed(0, K2, C2, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    collect(0, t, 0, pt, lat, n);
    chk("junk_next_plain", pt, P2);

    feed(0, K2, C2, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t + 15) @(negedge clk);
    chk("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    feed(0, K1, C1, 0, t);
    @(negedge clk);
    in_valid = 1'b0;
    collect(0, t, 0, pt, lat, n);
    chk("mid_after_plain", pt, P1);
    chk("mid_after_latency", lat, 22);

    feed(1, K1, C1, 0, t);
    @(negedge clk);
    in_valid1 = 1'b0;
    collect(1, t, 0, pt, lat, n);
    chk("loop_plain", pt, P1);
    chk("loop_latency", lat, 22);
    @(negedge clk);
    chk("loop_hold_byte", plain_byte1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
